// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package hazard_pkg;

    localparam int REG_W  = 5;
    localparam int TNEW_W = 2;

    // Forward-mux select codes; 4, 6 and 7 are never driven.
    localparam logic [2:0] FWD_OWN    = 3'd0;  // own pipeline / regfile value
    localparam logic [2:0] FWD_M_ALU  = 3'd1;  // M-stage ALU result
    localparam logic [2:0] FWD_W_LINK = 3'd2;  // W-stage PC4_W+8
    localparam logic [2:0] FWD_W_DATA = 3'd3;  // W-stage write data
    localparam logic [2:0] FWD_M_LINK = 3'd5;  // M-stage PC4_M+8

    localparam logic [1:0] KIND_ALU  = 2'd0;
    localparam logic [1:0] KIND_MEM  = 2'd1;
    localparam logic [1:0] KIND_LINK = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  dst;
        logic [TNEW_W-1:0] tnew;
        logic [1:0]        kind;
    } entry_t;

    // A producer matches a register only if it really writes it; $0 never matches.
    function automatic logic hit(input entry_t e, input logic [REG_W-1:0] r);
        return e.valid && (e.dst != '0) && (e.dst == r);
    endfunction

    // Entry as seen one stage later: tnew counts down and saturates at 0.
    function automatic entry_t age(input entry_t e);
        entry_t a;
        a = e;
        if (a.tnew != '0) begin
            a.tnew = a.tnew - TNEW_W'(1);
        end
        return a;
    endfunction

endpackage

// File: rtl/fwd_pick.sv
// Forward-source priority selector for one consumer operand (M beats W).
// Latency: purely combinational.
// Backpressure: none; the stall decision is made elsewhere.
//
// Ports: src   - consumer register index
//        m_ent - producer entry in M (tie to zero for W-only consumers)
//        w_ent - producer entry in W
//        sel   - forward-mux select code
module fwd_pick
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  entry_t           m_ent,
    input  entry_t           w_ent,
    output logic [2:0]       sel
);

    // W results are always final, so W's tnew carries no information here.
    logic unused_w_tnew;
    assign unused_w_tnew = &{1'b0, w_ent.tnew};

    always_comb begin
        sel = FWD_OWN;
        if (hit(m_ent, src)) begin
            // The youngest match shadows W even when it is not ready yet;
            // a load in M is never a source (its data only exists in W).
            if (m_ent.tnew == '0) begin
                if (m_ent.kind == KIND_ALU) begin
                    sel = FWD_M_ALU;
                end else if (m_ent.kind == KIND_LINK) begin
                    sel = FWD_M_LINK;
                end
            end
        end else if (hit(w_ent, src)) begin
            sel = (w_ent.kind == KIND_LINK) ? FWD_W_LINK : FWD_W_DATA;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline scoreboard for E/M/W producers: stall request and forward-mux selects.
// Latency: outputs combinational from state and D inputs; stall acts at next edge.
// Backpressure: stall freezes PC and F/D and injects a bubble into E.
//
// Ports: clk, rst_n (async active-low)
//        rs_d/rt_d, tuse_rs_d/tuse_rt_d - D-stage sources and their use times
//        dst_d, tnew_d, kind_d          - D-stage destination, result timing and kind
//        stall                          - hold F/D, bubble into E
//        fwd_rs_d/fwd_rt_d, fwd_rs_e/fwd_rt_e, fwd_rt_m - forward selects
module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter int TW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [TW-1:0]     tuse_rs_d,
    input  logic [TW-1:0]     tuse_rt_d,
    input  logic [REG_AW-1:0] dst_d,
    input  logic [TW-1:0]     tnew_d,
    input  logic [1:0]        kind_d,
    output logic              stall,
    output logic [2:0]        fwd_rs_d,
    output logic [2:0]        fwd_rt_d,
    output logic [2:0]        fwd_rs_e,
    output logic [2:0]        fwd_rt_e,
    output logic [2:0]        fwd_rt_m
);
    import hazard_pkg::*;

    entry_t           e_q, m_q, w_q;
    logic [REG_W-1:0] rs_e_q, rt_e_q, rt_m_q;
    entry_t           e_new;
    entry_t           no_ent;

    assign no_ent = '0;

    // Nothing forwards out of E, so a result is at best usable one cycle after entry.
    always_comb begin
        e_new       = '0;
        e_new.valid = 1'b1;
        e_new.dst   = REG_W'(dst_d);
        e_new.tnew  = (tnew_d == '0) ? TNEW_W'(1) : TNEW_W'(tnew_d);
        e_new.kind  = kind_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            rs_e_q <= '0;
            rt_e_q <= '0;
            rt_m_q <= '0;
        end else begin
            m_q    <= age(e_q);
            w_q    <= age(m_q);
            rt_m_q <= rt_e_q;
            if (stall) begin
                e_q    <= '0;
                rs_e_q <= '0;
                rt_e_q <= '0;
            end else begin
                e_q    <= e_new;
                rs_e_q <= REG_W'(rs_d);
                rt_e_q <= REG_W'(rt_d);
            end
        end
    end

    // Only the youngest matching producer counts: if E matches, M's copy is stale.
    function automatic logic must_wait(input entry_t e, input entry_t m,
                                       input logic [REG_W-1:0] r,
                                       input logic [TNEW_W-1:0] tuse);
        if (hit(e, r)) begin
            return e.tnew > tuse;
        end
        if (hit(m, r)) begin
            return m.tnew > tuse;
        end
        return 1'b0;
    endfunction

    assign stall = must_wait(e_q, m_q, REG_W'(rs_d), TNEW_W'(tuse_rs_d))
                 | must_wait(e_q, m_q, REG_W'(rt_d), TNEW_W'(tuse_rt_d));

    logic [2:0] pick_rs_d, pick_rt_d;

    fwd_pick u_pick_rs_d (.src(REG_W'(rs_d)), .m_ent(m_q), .w_ent(w_q), .sel(pick_rs_d));
    fwd_pick u_pick_rt_d (.src(REG_W'(rt_d)), .m_ent(m_q), .w_ent(w_q), .sel(pick_rt_d));
    fwd_pick u_pick_rs_e (.src(rs_e_q),       .m_ent(m_q), .w_ent(w_q), .sel(fwd_rs_e));
    fwd_pick u_pick_rt_e (.src(rt_e_q),       .m_ent(m_q), .w_ent(w_q), .sel(fwd_rt_e));
    fwd_pick u_pick_rt_m (.src(rt_m_q),       .m_ent(no_ent), .w_ent(w_q), .sel(fwd_rt_m));

    // A producer still in E shadows older M/W copies; the stall covers that case.
    assign fwd_rs_d = hit(e_q, REG_W'(rs_d)) ? FWD_OWN : pick_rs_d;
    assign fwd_rt_d = hit(e_q, REG_W'(rt_d)) ? FWD_OWN : pick_rt_d;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs_d = '0, rt_d = '0, dst_d = '0;
    logic [1:0] tuse_rs_d = '0, tuse_rt_d = '0, tnew_d = '0, kind_d = '0;
    logic       stall;
    logic [2:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

    hazard_fwd_unit #(.REG_AW(5), .TW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .dst_d(dst_d), .tnew_d(tnew_d), .kind_d(kind_d),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
    );

    always #5 clk = ~clk;

    // Instruction as presented in D; kind 0 ALU, 1 MEM, 2 LINK.
    typedef struct {int rs; int rt; int urs; int urt; int dst; int tnew; int kind;} ins_t;
    // In-flight instruction: rdy is the absolute cycle its result becomes usable.
    typedef struct {bit v; int dst; int kind; int rdy; int rs; int rt;} rec_t;
    typedef struct {logic stall; logic [2:0] frd; logic [2:0] frtd;
                    logic [2:0] fre; logic [2:0] frte; logic [2:0] frtm;} exp_t;

    rec_t pipe[3];   // [0]=E, [1]=M, [2]=W
    int   now = 0;
    exp_t exp_q[$];
    int   chk_cnt = 0;
    int   err_cnt = 0;

    function automatic ins_t mk(int rs, int rt, int urs, int urt, int dst, int tnew, int kind);
        ins_t x;
        x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
        x.dst = dst; x.tnew = tnew; x.kind = kind;
        return x;
    endfunction

    function automatic bit m_hit(rec_t p, int r);
        return p.v && p.dst != 0 && p.dst == r;
    endfunction

    function automatic int remaining(rec_t p);
        return (p.rdy > now) ? p.rdy - now : 0;
    endfunction

    // Youngest matching producer in E or M not yet ready in time for its use.
    function automatic bit blocks(int r, int tuse);
        for (int i = 0; i < 2; i++)
            if (m_hit(pipe[i], r)) return remaining(pipe[i]) > tuse;
        return 1'b0;
    endfunction

    // Youngest matching producer from stage index 'first' onwards.
    function automatic logic [2:0] pick(int r, int first);
        for (int i = first; i < 3; i++) begin
            if (m_hit(pipe[i], r)) begin
                if (i == 0) return 3'd0;
                if (i == 2) return (pipe[i].kind == 2) ? 3'd2 : 3'd3;
                if (remaining(pipe[i]) != 0) return 3'd0;
                if (pipe[i].kind == 0) return 3'd1;
                if (pipe[i].kind == 2) return 3'd5;
                return 3'd0;
            end
        end
        return 3'd0;
    endfunction

    function automatic exp_t predict(ins_t in);
        exp_t e;
        e.stall = blocks(in.rs, in.urs) || blocks(in.rt, in.urt);
        e.frd   = pick(in.rs, 0);
        e.frtd  = pick(in.rt, 0);
        e.fre   = pick(pipe[0].rs, 1);
        e.frte  = pick(pipe[0].rt, 1);
        e.frtm  = pick(pipe[1].rt, 2);
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    endtask

    task automatic model_advance(ins_t in, bit st);
        now++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (st) pipe[0] = '{default: 0};
        else    pipe[0] = '{1'b1, in.dst, in.kind, now + ((in.tnew < 1) ? 1 : in.tnew), in.rs, in.rt};
    endtask

    // One D-stage cycle: drive at the falling edge, post the expectation, step the model.
    task automatic step(input ins_t in, input bit rstv, output bit st);
        exp_t e;
        @(negedge clk);
        rst_n     = rstv;
        rs_d      = 5'(in.rs);
        rt_d      = 5'(in.rt);
        tuse_rs_d = 2'(in.urs);
        tuse_rt_d = 2'(in.urt);
        dst_d     = 5'(in.dst);
        tnew_d    = 2'(in.tnew);
        kind_d    = 2'(in.kind);
        if (!rstv) begin
            model_clear();
            e  = '{default: '0};
            st = 1'b0;
        end else begin
            e  = predict(in);
            st = e.stall;
        end
        exp_q.push_back(e);
        if (rstv) model_advance(in, e.stall);
    endtask

    // Hold the instruction in D until the model says it may leave.
    task automatic issue(input ins_t in);
        bit st;
        int n;
        n = 0;
        do begin
            step(in, 1'b1, st);
            n++;
        end while (st && n < 8);
    endtask

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
        chk_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare 1 time unit after each expectation.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() > 0);
            #1;
            e = exp_q.pop_front();
            chk("stall",    {2'b00, stall}, {2'b00, e.stall});
            chk("fwd_rs_d", fwd_rs_d, e.frd);
            chk("fwd_rt_d", fwd_rt_d, e.frtd);
            chk("fwd_rs_e", fwd_rs_e, e.fre);
            chk("fwd_rt_e", fwd_rt_e, e.frte);
            chk("fwd_rt_m", fwd_rt_m, e.frtm);
        end
    end

    ins_t dir[$];
    ins_t nop;

    initial begin
        bit   st;
        ins_t x;
        nop = mk(0, 0, 0, 0, 0, 0, 0);
        model_clear();

        // Reset state.
        step(nop, 1'b0, st);
        step(nop, 1'b0, st);

        dir.push_back(mk(1, 2, 1, 1, 3, 1, 0));   // addu $3
        dir.push_back(mk(3, 0, 1, 1, 8, 1, 0));   // consumer rs=$3, tuse 1
        dir.push_back(nop);
        dir.push_back(mk(1, 0, 1, 1, 5, 2, 1));   // lw $5
        dir.push_back(mk(0, 5, 1, 1, 9, 1, 0));   // consumer rt=$5, tuse 1
        dir.push_back(nop);
        dir.push_back(mk(1, 2, 1, 1, 4, 1, 0));   // addu $4
        dir.push_back(mk(4, 0, 0, 0, 0, 0, 0));   // beq rs=$4, tuse 0
        dir.push_back(nop);
        dir.push_back(mk(0, 0, 1, 1, 31, 0, 2));  // jal
        dir.push_back(mk(31, 0, 0, 0, 0, 0, 0));  // jr $31
        dir.push_back(nop);
        dir.push_back(mk(0, 6, 1, 1, 0, 1, 0));   // $0 producer, reads $6
        dir.push_back(mk(0, 0, 0, 0, 0, 1, 0));   // $0 consumer right behind
        dir.push_back(mk(1, 2, 1, 1, 7, 1, 0));   // addu $7
        dir.push_back(mk(2, 3, 1, 1, 7, 1, 0));   // addu $7 again
        dir.push_back(mk(7, 7, 1, 2, 10, 1, 0));  // consumer of $7 (M must win)
        dir.push_back(mk(0, 7, 1, 2, 0, 1, 0));   // store-like: rt=$7 needed late
        dir.push_back(nop);
        dir.push_back(nop);
        foreach (dir[i]) issue(dir[i]);

        // Randomized traffic over a small register window to force hazards.
        for (int n = 0; n < 400; n++) begin
            x.rs   = $urandom_range(0, 7);
            x.rt   = $urandom_range(0, 7);
            x.urs  = $urandom_range(0, 2);
            x.urt  = $urandom_range(0, 2);
            x.dst  = $urandom_range(0, 7);
            x.kind = $urandom_range(0, 2);
            x.tnew = (x.kind == 1) ? 2 : $urandom_range(0, 1);
            issue(x);
        end

        // Reset asserted in the middle of a load-use stall.
        issue(nop);
        issue(mk(1, 0, 1, 1, 5, 2, 1));            // lw $5
        step(mk(0, 5, 1, 1, 9, 1, 0), 1'b1, st);   // stall expected here
        #2;
        rst_n = 1'b0;
        model_clear();
        exp_q.push_back('{default: '0});
        step(mk(0, 5, 1, 1, 9, 1, 0), 1'b0, st);
        step(mk(0, 5, 1, 1, 9, 1, 0), 1'b1, st);   // restarts empty: no stall
        issue(mk(5, 9, 0, 0, 0, 0, 0));            // $9 still in E: stalls, then forwards
        for (int n = 0; n < 4; n++) issue(nop);

        for (int n = 0; n < 20 && exp_q.size() > 0; n++) #1;
        #2;
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
